axi4lite_reg_slave: RTL
=======================

AXI4LITE_REG_SLAVE -- requirements
Module: axi4lite_reg_slave

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32, data bus width; only 32 is supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 6, byte address width.
REQ-003 ACLK  in  1  single clock; all logic is rising-edge.
REQ-004 ARESET  in  1  reset, asynchronous, active-high.
REQ-005 S_AXI_AWADDR/AWPROT/AWVALID  in  6/3/1, AWREADY  out  1: write address channel.
REQ-006 S_AXI_WDATA/WSTRB/WVALID  in  32/4/1, WREADY  out  1: write data channel.
REQ-007 S_AXI_BRESP  out  2, BVALID  out  1, BREADY  in  1: write response channel.
REQ-008 S_AXI_ARADDR/ARPROT/ARVALID  in  6/3/1, ARREADY  out  1: read address channel.
REQ-009 S_AXI_RDATA  out  32, RRESP  out  2, RVALID  out  1, RREADY  in  1: read data channel.
REQ-010 reg0_o..reg3_o  out  32 each: current register contents to the FIFO datapath.

Function
REQ-011 Map: 0x00/0x04/0x08/0x0C = REG0..REG3 (RW); 0x10 = WCOUNT (RO, accepted-write count, 32-bit, wraps); 0x14-0x3F unmapped; address bits [1:0] are ignored.
REQ-012 Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
REQ-013 W_IDLE: AWREADY=WREADY=1; AW-only handshake -> W_HAVE_AW; W-only -> W_HAVE_W; both in the same cycle -> W_RESP.
REQ-014 W_HAVE_AW: AWREADY=0, WREADY=1; W handshake -> W_RESP. W_HAVE_W: WREADY=0, AWREADY=1; AW handshake -> W_RESP.
REQ-015 On entry to W_RESP, the register update and BVALID=1 take effect on the same edge; the updated value is visible on regN_o one cycle after the completing handshake.
REQ-016 Byte lane k of REGn is updated only when WSTRB[k]=1; WSTRB=0 leaves the register unchanged and still returns OKAY.
REQ-017 BRESP: OKAY (00) for 0x00-0x0C; SLVERR (10) for a write to 0x10 (no update); DECERR (11) for unmapped addresses (no update).
REQ-018 WCOUNT increments by 1 on every write that returns OKAY, including WSTRB=0; 0xFFFFFFFF wraps to 0.
REQ-019 W_RESP: AWREADY=WREADY=0; BVALID and BRESP are held stable until BREADY=1; then -> W_IDLE. One outstanding write maximum.
REQ-020 Read FSM states: R_IDLE (ARREADY=1, RVALID=0) and R_DATA (ARREADY=0, RVALID=1).
REQ-021 AR handshake in R_IDLE registers RDATA/RRESP and enters R_DATA; RVALID rises the cycle after the handshake.
REQ-022 RRESP: OKAY for 0x00-0x10; DECERR with RDATA=0 for unmapped addresses.
REQ-023 R_DATA holds RDATA/RRESP stable until RREADY=1, then -> R_IDLE; one outstanding read maximum.
REQ-024 Read and write FSMs are independent; a read sampled in the same cycle as a register update returns the pre-update value.
REQ-025 AWPROT and ARPROT are accepted and ignored.

Reset
REQ-026 ARESET=1 asynchronously forces both FSMs to IDLE; REG0..REG3=0, WCOUNT=0, BVALID=RVALID=0, BRESP=RRESP=00, RDATA=0.
REQ-027 In reset, AWREADY=WREADY=ARREADY=0; after ARESET deasserts they equal 1 from the first rising edge onward.
REQ-028 A transaction in flight at reset is discarded with no response, and no partial register update occurs.

Structure
REQ-029 Package axi4lite_reg_pkg holds the resp_t enum (OKAY/EXOKAY/SLVERR/DECERR), register offset constants, the write-state typedef and the read-state typedef.
REQ-030 Single module; no sub-module is required, since both FSMs and the register bank fit in one file.

Verification
REQ-031 Write 0x1, 0x2, 0x3, 0x4 to 0x00/0x04/0x08/0x0C, then read back -> RDATA 0x1..0x4, all RRESP=OKAY, WCOUNT reads 4.
REQ-032 W presented 3 cycles before AW (0x08, 0xDEADBEEF) -> exactly one BVALID pulse with OKAY, REG2=0xDEADBEEF.
REQ-033 REG0=0x11223344, then write 0xAABBCCDD with WSTRB=0101 -> REG0=0x11BB33DD.
REQ-034 Write to 0x10 -> SLVERR with WCOUNT unchanged; write to 0x20 -> DECERR; read 0x20 -> DECERR, RDATA=0.
REQ-035 BREADY/RREADY held low 5 cycles -> BVALID/RVALID and BRESP/RDATA/RRESP stay stable, no new AW/W/AR accepted, release completes the transfer.
REQ-036 ARESET asserted in W_HAVE_AW -> outputs take reset values immediately, no B response, REG values 0 after release.

Source files
------------

// File: rtl/axi4lite_reg_pkg.sv
// Shared types and register map for the AXI4-Lite control register slave.
// Latency: n/a (types only). Backpressure: n/a.
// Offsets are byte addresses with bits [1:0] already cleared.
package axi4lite_reg_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

    localparam logic [31:0] OFS_REG0   = 32'h00;
    localparam logic [31:0] OFS_REG1   = 32'h04;
    localparam logic [31:0] OFS_REG2   = 32'h08;
    localparam logic [31:0] OFS_REG3   = 32'h0C;
    localparam logic [31:0] OFS_WCOUNT = 32'h10;

    // WCOUNT is read-only, so a write to it is an error rather than a decode miss.
    function automatic resp_t decode_wr(input logic [31:0] ofs);
        if (ofs <= OFS_REG3)
            return RESP_OKAY;
        else if (ofs == OFS_WCOUNT)
            return RESP_SLVERR;
        else
            return RESP_DECERR;
    endfunction

    function automatic resp_t decode_rd(input logic [31:0] ofs);
        return (ofs <= OFS_WCOUNT) ? RESP_OKAY : RESP_DECERR;
    endfunction

endpackage

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite slave: four RW registers plus a read-only accepted-write counter.
// Latency: write response and read data are registered, one cycle after the completing handshake.
// Backpressure: one outstanding write and one outstanding read; B/R held until BREADY/RREADY.
module axi4lite_reg_slave
    import axi4lite_reg_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_o
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int SW = DW / 8;

    wstate_t             r_wstate, w_wstate_nxt;
    rstate_t             r_rstate, w_rstate_nxt;
    logic                r_rdy_en;
    logic [AW-1:0]       r_awaddr;
    logic [DW-1:0]       r_wdata;
    logic [SW-1:0]       r_wstrb;
    logic [DW-1:0]       r_reg [4];
    logic [31:0]         r_wcount;
    resp_t               r_bresp;
    logic [DW-1:0]       r_rdata;
    resp_t               r_rresp;

    logic                w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [AW-1:0]       w_wr_addr;
    logic [DW-1:0]       w_wr_data;
    logic [SW-1:0]       w_wr_strb;
    logic [31:0]         w_wr_ofs, w_rd_ofs;
    resp_t               w_wr_resp, w_rd_resp;
    logic [DW-1:0]       w_rd_val;
    logic                w_unused_ok;

    // Ready is held low in reset and for the first edge after it.
    assign S_AXI_AWREADY = r_rdy_en && (r_wstate == W_IDLE || r_wstate == W_HAVE_W);
    assign S_AXI_WREADY  = r_rdy_en && (r_wstate == W_IDLE || r_wstate == W_HAVE_AW);
    assign S_AXI_ARREADY = r_rdy_en && (r_rstate == R_IDLE);
    assign S_AXI_BVALID  = (r_wstate == W_RESP);
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_RVALID  = (r_rstate == R_DATA);
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;

    assign reg0_o = r_reg[0];
    assign reg1_o = r_reg[1];
    assign reg2_o = r_reg[2];
    assign reg3_o = r_reg[3];

    assign w_aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign w_ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs)
                    w_wstate_nxt = W_RESP;
                else if (w_aw_hs)
                    w_wstate_nxt = W_HAVE_AW;
                else if (w_w_hs)
                    w_wstate_nxt = W_HAVE_W;
            end
            W_HAVE_AW: if (w_w_hs)        w_wstate_nxt = W_RESP;
            W_HAVE_W:  if (w_aw_hs)       w_wstate_nxt = W_RESP;
            W_RESP:    if (S_AXI_BREADY)  w_wstate_nxt = W_IDLE;
            default:                      w_wstate_nxt = W_IDLE;
        endcase
    end

    // The completing beat may arrive this cycle, so bypass the capture registers.
    assign w_commit  = (r_wstate != W_RESP) && (w_wstate_nxt == W_RESP);
    assign w_wr_addr = w_aw_hs ? S_AXI_AWADDR : r_awaddr;
    assign w_wr_data = w_w_hs  ? S_AXI_WDATA  : r_wdata;
    assign w_wr_strb = w_w_hs  ? S_AXI_WSTRB  : r_wstrb;
    assign w_wr_ofs  = 32'({w_wr_addr[AW-1:2], 2'b00});
    assign w_wr_resp = decode_wr(w_wr_ofs);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wstate <= W_IDLE;
            r_rdy_en <= 1'b0;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= RESP_OKAY;
            r_wcount <= '0;
            for (int i = 0; i < 4; i++)
                r_reg[i] <= '0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rdy_en <= 1'b1;
            if (w_aw_hs)
                r_awaddr <= S_AXI_AWADDR;
            if (w_w_hs) begin
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end
            if (w_commit) begin
                r_bresp <= w_wr_resp;
                if (w_wr_resp == RESP_OKAY) begin
                    r_wcount <= r_wcount + 32'd1;
                    for (int k = 0; k < SW; k++)
                        if (w_wr_strb[k])
                            r_reg[w_wr_ofs[3:2]][8*k +: 8] <= w_wr_data[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs)       w_rstate_nxt = R_DATA;
            R_DATA:  if (S_AXI_RREADY)  w_rstate_nxt = R_IDLE;
            default:                    w_rstate_nxt = R_IDLE;
        endcase
    end

    assign w_rd_ofs  = 32'({S_AXI_ARADDR[AW-1:2], 2'b00});
    assign w_rd_resp = decode_rd(w_rd_ofs);

    always_comb begin
        w_rd_val = '0;
        if (w_rd_ofs <= OFS_REG3)
            w_rd_val = r_reg[w_rd_ofs[3:2]];
        else if (w_rd_ofs == OFS_WCOUNT)
            w_rd_val = DW'(r_wcount);
    end

    // Sampling r_reg here on the same edge as a write yields the pre-update value.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (w_ar_hs) begin
                r_rdata <= w_rd_val;
                r_rresp <= w_rd_resp;
            end
        end
    end

    assign w_unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0],
                           w_wr_ofs[1:0], w_rd_ofs[1:0]};

endmodule
